// File: rtl/ion_stream_reader.sv
// ion_stream_reader: consumer end of the ion sensor stream interface.
// Picks one pending stream round-robin, captures its frame, acks it and
// serializes {header, payload bytes MSB first[, checksum]} on a valid/ready
// byte port. One frame in flight at a time.
// Optional feature macro: ION_READER_CHECKSUM_EN (appends an XOR checksum byte).
`timescale 1ns/1ps

module ion_stream_reader #(
    parameter int unsigned NUM_STREAMS = 8,
    parameter int unsigned SEL_WIDTH   = 3,
    parameter int unsigned DATA_WIDTH  = 110,
    parameter int unsigned NUM_BYTES   = 14,
    parameter logic [4:0]  HDR_TAG     = 5'b10101
) (
    input  logic                   i_clock,
    input  logic                   i_resetn,
    input  logic [NUM_STREAMS-1:0] i_sensor_ready,
    input  logic [DATA_WIDTH-1:0]  i_sensor_data,
    output logic [SEL_WIDTH-1:0]   o_sensor_select,
    output logic [NUM_STREAMS-1:0] o_sensor_ack,
    output logic [7:0]             o_byte_out,
    output logic                   o_byte_valid,
    input  logic                   i_byte_ready,
    output logic                   o_busy
);

    localparam int unsigned PAD_WIDTH = NUM_BYTES * 8;
    localparam int unsigned CNT_WIDTH = (NUM_BYTES > 1) ? $clog2(NUM_BYTES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StCapture,
        StSendHdr,
        StSendData
`ifdef ION_READER_CHECKSUM_EN
        , StSendCsum
`endif
    } state_e;

    state_e                  r_state;
    logic [SEL_WIDTH-1:0]    r_sel;
    logic [SEL_WIDTH-1:0]    r_last;
    logic [DATA_WIDTH-1:0]   r_frame;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [7:0]              r_byte;
    logic                    r_valid;
`ifdef ION_READER_CHECKSUM_EN
    logic [7:0]              r_csum;
`endif

    logic                    w_found;
    logic [SEL_WIDTH-1:0]    w_winner;
    logic [SEL_WIDTH-1:0]    w_idx;
    logic [PAD_WIDTH-1:0]    w_frame_pad;
    logic [CNT_WIDTH-1:0]    w_next_idx;
    int unsigned             w_shift;
    logic [7:0]              w_next_byte;
    logic [7:0]              w_header;
    logic                    w_xfer;

    // Frame zero-extended at the top to a whole number of bytes.
    assign w_frame_pad = PAD_WIDTH'(r_frame);
    assign w_header    = 8'({HDR_TAG, r_sel});
    assign w_xfer      = r_valid && i_byte_ready;

    assign o_sensor_select = r_sel;
    assign o_byte_out      = r_byte;
    assign o_byte_valid    = r_valid;
    assign o_busy          = (r_state != StIdle);

    // Round-robin search: first pending stream after the last one served.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= int'(NUM_STREAMS); i++) begin
            w_idx = SEL_WIDTH'((int'(r_last) + i) % int'(NUM_STREAMS));
            if (!w_found && i_sensor_ready[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Next payload byte to present: index 0 from the header, else count+1.
    always_comb begin
        w_next_idx = (r_state == StSendData) ? (r_cnt + CNT_WIDTH'(1)) : '0;
        w_shift    = 0;
        if (w_next_idx <= LAST_CNT) begin
            w_shift = (NUM_BYTES - 1 - 32'(w_next_idx)) * 8;
        end
        w_next_byte = 8'(w_frame_pad >> w_shift);
    end

    // Ack is a combinational pulse so it tracks ready in the CAPTURE cycle itself.
    always_comb begin
        o_sensor_ack = '0;
        if (r_state == StCapture && i_sensor_ready[r_sel]) begin
            o_sensor_ack[r_sel] = 1'b1;
        end
    end

    // Main FSM with registered select, byte and valid outputs.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= StIdle;
            r_sel   <= '0;
            r_last  <= SEL_WIDTH'(NUM_STREAMS - 1);
            r_frame <= '0;
            r_cnt   <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
`ifdef ION_READER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_sel   <= w_winner;
                        r_state <= StSelect;
                    end
                end
                // Give the producer mux one cycle to settle on the new select.
                StSelect: begin
                    r_state <= StCapture;
                end
                StCapture: begin
                    if (i_sensor_ready[r_sel]) begin
                        r_frame <= i_sensor_data;
                        r_last  <= r_sel;
                        r_cnt   <= '0;
                        r_byte  <= w_header;
                        r_valid <= 1'b1;
`ifdef ION_READER_CHECKSUM_EN
                        r_csum  <= w_header;
`endif
                        r_state <= StSendHdr;
                    end else begin
                        // Producer withdrew the frame; nothing consumed.
                        r_state <= StIdle;
                    end
                end
                StSendHdr: begin
                    if (w_xfer) begin
                        r_byte  <= w_next_byte;
                        r_cnt   <= '0;
`ifdef ION_READER_CHECKSUM_EN
                        r_csum  <= r_csum ^ w_next_byte;
`endif
                        r_state <= StSendData;
                    end
                end
                StSendData: begin
                    if (w_xfer) begin
                        if (r_cnt == LAST_CNT) begin
`ifdef ION_READER_CHECKSUM_EN
                            r_byte  <= r_csum;
                            r_state <= StSendCsum;
`else
                            r_valid <= 1'b0;
                            r_state <= StIdle;
`endif
                        end else begin
                            r_cnt  <= r_cnt + CNT_WIDTH'(1);
                            r_byte <= w_next_byte;
`ifdef ION_READER_CHECKSUM_EN
                            r_csum <= r_csum ^ w_next_byte;
`endif
                        end
                    end
                end
`ifdef ION_READER_CHECKSUM_EN
                StSendCsum: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_state <= StIdle;
                    end
                end
`endif
                default: begin
                    r_valid <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Interface invariants.
    a_ack_onehot: assert property (@(posedge i_clock) disable iff (!i_resetn)
        $onehot0(o_sensor_ack));
    a_ack_in_capture: assert property (@(posedge i_clock) disable iff (!i_resetn)
        (o_sensor_ack != '0) |-> (r_state == StCapture));
    a_byte_hold: assert property (@(posedge i_clock) disable iff (!i_resetn)
        (o_byte_valid && !i_byte_ready) |=> (o_byte_valid && $stable(o_byte_out)));

endmodule
